// File: rtl/fa_bist_pkg.sv
// ---------------------------------------------------------------------------
// fa_bist_pkg
// Shared definitions for the full-adder self-test engine: the sweep state
// machine encoding, the vector space of a full adder, and the width of the
// per-vector settle counter.
// No ports (package).
// ---------------------------------------------------------------------------
package fa_bist_pkg;

    // Sweep controller states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // A full adder has three inputs {ci,a,b}, so eight vectors per sweep
    localparam int VEC_W    = 3;
    localparam int NUM_VEC  = 8;
    localparam int SETTLE_W = 4;

    localparam logic [VEC_W-1:0] LAST_VEC = VEC_W'(NUM_VEC - 1);

endpackage

// File: rtl/fa_ref_model.sv
// ---------------------------------------------------------------------------
// fa_ref_model
// Combinational golden full adder used as the reference for every DUT.
// Ports:
//   a, b, ci  in   adder operands and carry-in
//   s         out  sum       = a ^ b ^ ci
//   co        out  carry-out = majority(a, b, ci)
// ---------------------------------------------------------------------------
module fa_ref_model (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/fa_bist.sv
// ---------------------------------------------------------------------------
// fa_bist
// Self-test engine for up to eight full-adder instances. One start pulse
// sweeps the eight {ci,a,b} vectors in ascending order, holds each one for
// SETTLE_CYCLES+1 cycles, then compares every DUT's sum/carry against a
// golden adder and accumulates an error count and failure masks.
//
// Parameters:
//   N_DUT          number of adders checked in parallel (1..8)
//   SETTLE_CYCLES  extra hold cycles per vector before sampling (0..15)
// Ports:
//   clk               in   rising-edge clock
//   rst_n             in   asynchronous active-low reset
//   start             in   one-cycle sweep request, honoured only when idle
//   drv_ci/drv_a/drv_b out registered stimulus shared by all DUTs
//   rsp_s, rsp_co     in   DUT sum / carry outputs, bit i = DUT i
//   busy              out  high while a sweep runs
//   done              out  one-cycle pulse after the last vector check
//   pass              out  1 when the last completed sweep saw no errors
//   err_cnt           out  number of failing (vector, DUT) pairs
//   fail_mask         out  bit v set if any DUT failed vector v
//   fail_dut          out  bit i set if DUT i failed any vector
// Optional (macro FA_BIST_FIRST_FAIL_EN):
//   first_fail_valid  out  set on the first failing check of a sweep
//   first_fail_vec    out  vector index of that first failing check
// ---------------------------------------------------------------------------
module fa_bist
    import fa_bist_pkg::*;
#(
    parameter int N_DUT         = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            start,
    output logic                            drv_ci,
    output logic                            drv_a,
    output logic                            drv_b,
    input  logic [N_DUT-1:0]                rsp_s,
    input  logic [N_DUT-1:0]                rsp_co,
    output logic                            busy,
    output logic                            done,
    output logic                            pass,
    output logic [$clog2(8*N_DUT+1)-1:0]    err_cnt,
    output logic [NUM_VEC-1:0]              fail_mask,
`ifdef FA_BIST_FIRST_FAIL_EN
    output logic                            first_fail_valid,
    output logic [VEC_W-1:0]                first_fail_vec,
`endif
    output logic [N_DUT-1:0]                fail_dut
);

    localparam int CNT_W = $clog2(8*N_DUT+1);

    localparam logic [SETTLE_W-1:0] SETTLE_INIT = SETTLE_W'(SETTLE_CYCLES);

    state_t              state;
    logic [VEC_W-1:0]    vec;
    logic [SETTLE_W-1:0] settle;

    logic                exp_s;
    logic                exp_co;
    logic [N_DUT-1:0]    fail_now;
    logic [CNT_W-1:0]    fail_num;
    logic [CNT_W-1:0]    err_next;
    logic                check_now;

    // The golden adder sees exactly what the DUTs see, so its output is
    // aligned with the responses it is compared against.
    fa_ref_model u_ref (
        .a  (drv_a),
        .b  (drv_b),
        .ci (drv_ci),
        .s  (exp_s),
        .co (exp_co)
    );

    // Per-DUT verdict for the current vector. A DUT with both outputs wrong
    // still contributes a single error, hence the OR before counting.
    always_comb begin
        fail_now = '0;
        fail_num = '0;
        for (int i = 0; i < N_DUT; i++) begin
            fail_now[i] = (rsp_s[i] != exp_s) || (rsp_co[i] != exp_co);
            fail_num    = fail_num + CNT_W'(fail_now[i]);
        end
        err_next  = err_cnt + fail_num;
        check_now = (state == RUN) && (settle == '0);
    end

    // Sweep controller with all outputs registered. The settle counter is
    // loaded each time a vector is put on the bus and the check happens on
    // the edge where it is already zero, giving SETTLE_CYCLES+1 cycles of
    // hold per vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= IDLE;
            vec              <= '0;
            settle           <= '0;
            drv_ci           <= 1'b0;
            drv_a            <= 1'b0;
            drv_b            <= 1'b0;
            busy             <= 1'b0;
            done             <= 1'b0;
            pass             <= 1'b0;
            err_cnt          <= '0;
            fail_mask        <= '0;
            fail_dut         <= '0;
`ifdef FA_BIST_FIRST_FAIL_EN
            first_fail_valid <= 1'b0;
            first_fail_vec   <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        state            <= RUN;
                        vec              <= '0;
                        settle           <= SETTLE_INIT;
                        {drv_ci, drv_a, drv_b} <= '0;
                        busy             <= 1'b1;
                        pass             <= 1'b0;
                        err_cnt          <= '0;
                        fail_mask        <= '0;
                        fail_dut         <= '0;
`ifdef FA_BIST_FIRST_FAIL_EN
                        first_fail_valid <= 1'b0;
                        first_fail_vec   <= '0;
`endif
                    end
                end

                RUN: begin
                    if (check_now) begin
                        err_cnt        <= err_next;
                        fail_mask[vec] <= fail_mask[vec] | (|fail_now);
                        fail_dut       <= fail_dut | fail_now;
`ifdef FA_BIST_FIRST_FAIL_EN
                        // Only the first failing check of a sweep is kept
                        if (!first_fail_valid && (|fail_now)) begin
                            first_fail_valid <= 1'b1;
                            first_fail_vec   <= vec;
                        end
`endif
                        if (vec == LAST_VEC) begin
                            // err_next already includes the final vector
                            state <= FIN;
                            pass  <= (err_next == '0);
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            {drv_ci, drv_a, drv_b} <= '0;
                        end else begin
                            vec    <= vec + VEC_W'(1);
                            settle <= SETTLE_INIT;
                            {drv_ci, drv_a, drv_b} <= vec + VEC_W'(1);
                        end
                    end else begin
                        settle <= settle - SETTLE_W'(1);
                    end
                end

                FIN: begin
                    // One-cycle completion slot; start is not looked at here
                    done  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fa_bist.sv
// ---------------------------------------------------------------------------
// tb_fa_bist
// Self-checking bench for fa_bist. Three behavioural adders are modelled in
// the bench; each can have its sum and/or carry flipped on any subset of
// vectors. Expected results are derived from those fault masks by counting.
// Optional feature checked when FA_BIST_FIRST_FAIL_EN is defined.
// ---------------------------------------------------------------------------
module tb_fa_bist;

    localparam int N_DUT  = 3;
    localparam int SETTLE = 2;
    localparam int CNT_W  = $clog2(8*N_DUT+1);
    localparam int SWEEP  = 8*(SETTLE+1);

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               start = 1'b0;
    logic               drv_ci, drv_a, drv_b;
    logic [N_DUT-1:0]   rsp_s, rsp_co;
    logic               busy, done, pass;
    logic [CNT_W-1:0]   err_cnt;
    logic [7:0]         fail_mask;
    logic [N_DUT-1:0]   fail_dut;
`ifdef FA_BIST_FIRST_FAIL_EN
    logic               first_fail_valid;
    logic [2:0]         first_fail_vec;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] flip_s  [N_DUT];
    logic [7:0] flip_co [N_DUT];

    fa_bist #(
        .N_DUT         (N_DUT),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .drv_ci           (drv_ci),
        .drv_a            (drv_a),
        .drv_b            (drv_b),
        .rsp_s            (rsp_s),
        .rsp_co           (rsp_co),
        .busy             (busy),
        .done             (done),
        .pass             (pass),
        .err_cnt          (err_cnt),
        .fail_mask        (fail_mask),
`ifdef FA_BIST_FIRST_FAIL_EN
        .first_fail_valid (first_fail_valid),
        .first_fail_vec   (first_fail_vec),
`endif
        .fail_dut         (fail_dut)
    );

    always #5 clk = ~clk;

    // Behavioural adders: arithmetic sum of the three input bits, with the
    // configured fault masks applied per vector
    always_comb begin
        int v;
        int total;
        rsp_s  = '0;
        rsp_co = '0;
        v      = int'({drv_ci, drv_a, drv_b});
        total  = int'(drv_ci) + int'(drv_a) + int'(drv_b);
        for (int i = 0; i < N_DUT; i++) begin
            rsp_s[i]  = total[0] ^ flip_s[i][v];
            rsp_co[i] = total[1] ^ flip_co[i][v];
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // DUT i's masks live at bits [8i +: 8]
    task automatic applyStimulus(input logic [8*N_DUT-1:0] fs, input logic [8*N_DUT-1:0] fco);
        for (int i = 0; i < N_DUT; i++) begin
            flip_s[i]  = fs[8*i +: 8];
            flip_co[i] = fco[8*i +: 8];
        end
    endtask

    // Expected results from the fault masks: every (vector, DUT) pair with
    // any wrong output is one error
    task automatic computeExpected(output int e_cnt, output logic [7:0] e_mask,
                                   output logic [N_DUT-1:0] e_dut,
                                   output logic e_ffv, output logic [2:0] e_ffvec);
        e_cnt = 0; e_mask = '0; e_dut = '0; e_ffv = 1'b0; e_ffvec = '0;
        for (int v = 0; v < 8; v++) begin
            for (int i = 0; i < N_DUT; i++) begin
                if (flip_s[i][v] || flip_co[i][v]) begin
                    e_cnt++;
                    e_mask[v] = 1'b1;
                    e_dut[i]  = 1'b1;
                    if (!e_ffv) begin
                        e_ffv   = 1'b1;
                        e_ffvec = 3'(v);
                    end
                end
            end
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {busy, done, pass, err_cnt, fail_mask, fail_dut, drv_ci, drv_a, drv_b}, 32'd0);
`ifdef FA_BIST_FIRST_FAIL_EN
        checkOutput({tag, "_ff"}, {first_fail_valid, first_fail_vec}, 32'd0);
`endif
    endtask

    // One sweep with timing checks; optional start re-pulse and reset abort
    task automatic runSweep(input int repulse_cycle, input int reset_cycle);
        int busy_cycles = 0;
        int done_cycle  = 0;
        int done_cycles = 0;
        int vec_errs    = 0;
        int e_cnt;
        logic [7:0] e_mask;
        logic [N_DUT-1:0] e_dut;
        logic e_ffv;
        logic [2:0] e_ffvec;
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= SWEEP + 10; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0;
                checkOutput("start_clears", {pass, err_cnt, fail_mask, fail_dut}, 32'd0);
                checkOutput("busy_after_start", busy, 1);
            end
            if (repulse_cycle > 0 && c == repulse_cycle)     start = 1'b1;
            if (repulse_cycle > 0 && c == repulse_cycle + 1) start = 1'b0;
            if (reset_cycle > 0 && c == reset_cycle) begin
                rst_n = 1'b0;
                #1;
                checkAllZero("reset_abort");
                return;
            end
            if (busy) busy_cycles++;
            if (done) begin
                done_cycles++;
                if (done_cycle == 0) done_cycle = c;
            end
            if (c <= SWEEP) begin
                if (int'({drv_ci, drv_a, drv_b}) != (c-1)/(SETTLE+1)) vec_errs++;
            end else if ({drv_ci, drv_a, drv_b} != 3'b000) begin
                vec_errs++;
            end
        end
        checkOutput("busy_cycles", busy_cycles, SWEEP);
        checkOutput("done_cycle", done_cycle, SWEEP + 1);
        checkOutput("done_width", done_cycles, 1);
        checkOutput("drv_sequence", vec_errs, 0);
        computeExpected(e_cnt, e_mask, e_dut, e_ffv, e_ffvec);
        checkOutput("model_err_cnt", err_cnt, e_cnt);
        checkOutput("model_fail_mask", fail_mask, e_mask);
        checkOutput("model_fail_dut", fail_dut, e_dut);
        checkOutput("model_pass", pass, (e_cnt == 0));
`ifdef FA_BIST_FIRST_FAIL_EN
        checkOutput("model_ff_valid", first_fail_valid, e_ffv);
        if (e_ffv) checkOutput("model_ff_vec", first_fail_vec, e_ffvec);
`endif
    endtask

    task automatic checkDirected(input string tag, input int e_cnt, input logic [7:0] e_mask,
                                 input logic [N_DUT-1:0] e_dut);
        checkOutput({tag, "_err_cnt"}, err_cnt, e_cnt);
        checkOutput({tag, "_fail_mask"}, fail_mask, e_mask);
        checkOutput({tag, "_fail_dut"}, fail_dut, e_dut);
        checkOutput({tag, "_pass"}, pass, (e_cnt == 0));
    endtask

    initial begin
        logic [7:0] co_one;
        int idle_busy;
        // Vectors whose correct carry is 1 (two or more inputs set)
        co_one = '0;
        for (int v = 0; v < 8; v++) co_one[v] = ($countones(3'(v)) >= 2);

        applyStimulus('0, '0);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checkAllZero("reset_state");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] clean adders");
        applyStimulus('0, '0);
        runSweep(0, 0);
        checkDirected("clean", 0, 8'h00, 3'b000);

        $display("[TB] DUT1 carry stuck at 0");
        applyStimulus('0, {8'h00, co_one, 8'h00});
        runSweep(0, 0);
        checkDirected("co_stuck", 4, 8'hE8, 3'b010);
`ifdef FA_BIST_FIRST_FAIL_EN
        checkOutput("co_stuck_ff_vec", first_fail_vec, 3'b011);
`endif

        $display("[TB] DUT2 sum inverted, DUT0 carry inverted");
        applyStimulus({8'hFF, 8'h00, 8'h00}, {8'h00, 8'h00, 8'hFF});
        runSweep(0, 0);
        checkDirected("mixed", 16, 8'hFF, 3'b101);

        $display("[TB] DUT0 both outputs wrong on vector 0");
        applyStimulus({8'h00, 8'h00, 8'h01}, {8'h00, 8'h00, 8'h01});
        runSweep(0, 0);
        checkDirected("double_fault", 1, 8'h01, 3'b001);

        $display("[TB] start re-pulsed mid-sweep");
        applyStimulus('0, '0);
        runSweep(10, 0);
        checkDirected("repulse", 0, 8'h00, 3'b000);

        $display("[TB] randomized fault masks");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(24'($urandom & $urandom), 24'($urandom & $urandom & $urandom));
            runSweep(0, 0);
        end

        $display("[TB] reset mid-sweep");
        applyStimulus({8'hFF, 8'h00, 8'h00}, '0);
        runSweep(0, 12);
        @(negedge clk);
        rst_n = 1'b1;
        idle_busy = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy) idle_busy++;
        end
        checkOutput("idle_after_reset", idle_busy, 0);
        applyStimulus('0, '0);
        runSweep(0, 0);
        checkDirected("after_reset", 0, 8'h00, 3'b000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
